// File: rtl/ac_pkg.sv
// Shared types and default timing constants for the compressor controller.
package ac_pkg;

  // Controller states; the numeric values are visible on state_o.
  typedef enum logic [2:0] {
    StOffLock  = 3'd0,
    StOffReady = 3'd1,
    StCoolLock = 3'd2,
    StCoolRun  = 3'd3,
    StFault    = 3'd4
  } ac_state_e;

  localparam int unsigned TICK_DIV_DEFAULT  = 100000;
  localparam int unsigned MIN_ON_S_DEFAULT  = 600;
  localparam int unsigned MIN_OFF_S_DEFAULT = 900;

endpackage

// File: rtl/ac_compressor_ctrl_if.sv
// Sensor/drive bundle between the plant-side logic and the compressor controller.
interface ac_compressor_ctrl_if #(
  parameter int unsigned WIDTH = 5
);

  logic [WIDTH:0] s1_i;
  logic [WIDTH:0] s2_i;
  logic [WIDTH:0] setpoint_i;
  logic           enable_i;
  logic           compressor_o;
  logic           fan_o;
  logic [2:0]     state_o;
  logic           sec_tick_o;
  logic           fault_o;

  // Sensor/user side: supplies temperatures and requests, observes the drives.
  modport master (
    output s1_i, s2_i, setpoint_i, enable_i,
    input  compressor_o, fan_o, state_o, sec_tick_o, fault_o
  );

  // Controller side.
  modport slave (
    input  s1_i, s2_i, setpoint_i, enable_i,
    output compressor_o, fan_o, state_o, sec_tick_o, fault_o
  );

endinterface

// File: rtl/ac_sec_tick.sv
// Prescaler producing a one-cycle pulse every TICK_DIV clocks.
module ac_sec_tick
  import ac_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Free-running 0..TICK_DIV-1 counter, restarted by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/ac_compressor_ctrl.sv
// Compressor/fan sequencer: averaged temperature vs setpoint with hysteresis,
// minimum on/off lockouts counted in seconds, and sensor-disagreement fault.
module ac_compressor_ctrl
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int unsigned MIN_ON_S    = MIN_ON_S_DEFAULT,
  parameter int unsigned MIN_OFF_S   = MIN_OFF_S_DEFAULT,
  parameter int unsigned HYST        = 2,
  parameter int unsigned FAULT_DELTA = 8
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  ac_compressor_ctrl_if.slave bus
);

  // One extra bit so sums and setpoint+HYST never wrap.
  localparam int unsigned TW = WIDTH + 2;
  localparam int unsigned CntMax = (MIN_ON_S > MIN_OFF_S) ? MIN_ON_S : MIN_OFF_S;
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
  localparam logic [CntW-1:0] OnLoad  = CntW'(MIN_ON_S);
  localparam logic [CntW-1:0] OffLoad = CntW'(MIN_OFF_S);
  localparam logic [TW-1:0]   HystW   = TW'(HYST);
  localparam logic [TW-1:0]   DeltaW  = TW'(FAULT_DELTA);

  logic            tick;
  logic [TW-1:0]   s1_w, s2_w, sp_w;
  logic [TW-1:0]   sum, temp, diff, hi_thr, lo_thr;
  logic            sensor_fault, want_cool, want_off;
  ac_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            comp_q, fan_q, fault_q;

  ac_sec_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .tick_o  (tick)
  );

  // Temperature average, sensor spread and hysteresis thresholds.
  always_comb begin
    s1_w   = TW'(bus.s1_i);
    s2_w   = TW'(bus.s2_i);
    sp_w   = TW'(bus.setpoint_i);
    sum    = s1_w + s2_w;
    temp   = sum >> 1;
    diff   = (s1_w >= s2_w) ? (s1_w - s2_w) : (s2_w - s1_w);
    hi_thr = sp_w + HystW;
    lo_thr = (sp_w >= HystW) ? (sp_w - HystW) : '0;
    sensor_fault = (diff > DeltaW);
    want_cool    = bus.enable_i && (temp >= hi_thr);
    want_off     = !bus.enable_i || (temp <= lo_thr);
  end

  // Next state and lock timer; a fault pre-empts every state including locks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sensor_fault) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StOffLock: begin
          if (tick) begin
            // Leaving on the tick that would take the count to zero.
            if (cnt_q <= CntW'(1)) begin
              state_d = StOffReady;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        StOffReady: begin
          if (want_cool) begin
            state_d = StCoolLock;
            cnt_d   = OnLoad;
          end
        end
        StCoolLock: begin
          if (tick) begin
            if (cnt_q <= CntW'(1)) begin
              state_d = StCoolRun;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        StCoolRun: begin
          if (want_off) begin
            state_d = StOffLock;
            cnt_d   = OffLoad;
          end
        end
        StFault: begin
          state_d = StOffLock;
          cnt_d   = OffLoad;
        end
        default: state_d = StFault;
      endcase
    end
  end

  // State, timer and drive registers; drives are decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StOffLock;
      cnt_q   <= OffLoad;
      comp_q  <= 1'b0;
      fan_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      comp_q  <= (state_d == StCoolLock) || (state_d == StCoolRun);
      fan_q   <= (state_d == StCoolLock) || (state_d == StCoolRun);
      fault_q <= (state_d == StFault);
    end
  end

  assign bus.compressor_o = comp_q;
  assign bus.fan_o        = fan_q;
  assign bus.fault_o      = fault_q;
  assign bus.state_o      = state_q;
  assign bus.sec_tick_o   = tick;

endmodule

// File: tb/tb_ac_compressor_ctrl.sv
// Scenario bench for ac_compressor_ctrl with a seconds-counting reference model.
module tb_ac_compressor_ctrl;

  localparam int TD   = 4;
  localparam int MON  = 3;
  localparam int MOFF = 5;
  localparam int H    = 2;
  localparam int FD   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ac_compressor_ctrl_if #(.WIDTH(5)) bus ();

  ac_compressor_ctrl #(
    .WIDTH       (5),
    .TICK_DIV    (TD),
    .MIN_ON_S    (MON),
    .MIN_OFF_S   (MOFF),
    .HYST        (H),
    .FAULT_DELTA (FD)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: state number, seconds spent in current lock, prescaler phase.
  int m_state = 0;
  int m_secs  = 0;
  int m_pc    = 0;

  task automatic model_step();
    int s1, s2, sp, avg, d, hi, lo;
    bit tick;
    if (rst_n !== 1'b1) begin
      m_state = 0;
      m_secs  = 0;
      m_pc    = 0;
      return;
    end
    s1   = int'(bus.s1_i);
    s2   = int'(bus.s2_i);
    sp   = int'(bus.setpoint_i);
    avg  = (s1 + s2) / 2;
    d    = (s1 > s2) ? s1 - s2 : s2 - s1;
    hi   = sp + H;
    lo   = (sp > H) ? sp - H : 0;
    tick = (m_pc == TD - 1);
    m_pc = (m_pc + 1) % TD;
    if (d > FD) begin
      m_state = 4;
      return;
    end
    case (m_state)
      0: if (tick) begin
        m_secs++;
        if (m_secs >= MOFF) m_state = 1;
      end
      1: if (bus.enable_i && avg >= hi) begin
        m_state = 2;
        m_secs  = 0;
      end
      2: if (tick) begin
        m_secs++;
        if (m_secs >= MON) m_state = 3;
      end
      3: if (!bus.enable_i || avg <= lo) begin
        m_state = 0;
        m_secs  = 0;
      end
      default: begin
        m_state = 0;
        m_secs  = 0;
      end
    endcase
  endtask

  function automatic logic [6:0] exp_vec();
    logic [2:0] st;
    logic c;
    st = 3'(m_state);
    c  = (m_state == 2) || (m_state == 3);
    return {st, c, c, (m_state == 4), (m_pc == TD - 1)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {bus.state_o, bus.compressor_o, bus.fan_o, bus.fault_o, bus.sec_tick_o};
  endfunction

  // Model sees the inputs present at the edge, then the DUT is sampled 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_temp(input int s1, input int s2);
    bus.s1_i = 6'(s1);
    bus.s2_i = 6'(s2);
  endtask

  task automatic wait_model(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (m_state == target) break;
      cycle();
    end
    ok = (m_state == target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable_i = 1'b1;
    bus.setpoint_i = 6'd20;
    set_temp(30, 30);
    repeat (2) cycle();
    checks++;
    if (dut_vec() !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", dut_vec(), 7'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    int bad = 0;
    int ticks = 0;
    for (int i = 1; i <= 19; i++) begin
      cycle();
      if (bus.state_o !== 3'd0 || bus.compressor_o !== 1'b0) bad++;
      if (bus.sec_tick_o === 1'b1) ticks++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL power_up_hold: %0d bad cycles, want 0", bad);
    end
    checks++;
    if (ticks != MOFF) begin
      errors++;
      $display("FAIL power_up_ticks: got %0d want %0d", ticks, MOFF);
    end
    cycle();
    checks++;
    if (bus.state_o !== 3'd1 || bus.compressor_o !== 1'b0) begin
      errors++;
      $display("FAIL power_up_ready: state %0d comp %b want 1/0", bus.state_o, bus.compressor_o);
    end
    cycle();
    checks++;
    if ({bus.state_o, bus.compressor_o, bus.fan_o} !== {3'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL power_up_cool: state %0d comp %b fan %b want 2/1/1",
               bus.state_o, bus.compressor_o, bus.fan_o);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL power_up_model: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_min_on();
    int ticks = 0;
    int bad = 0;
    int n = 0;
    bus.enable_i = 1'b0;
    set_temp(10, 10);
    while (bus.state_o === 3'd2 && n < 40) begin
      if (bus.sec_tick_o === 1'b1) ticks++;
      if (bus.compressor_o !== 1'b1) bad++;
      cycle();
      n++;
    end
    checks++;
    if (ticks != MON || bad != 0) begin
      errors++;
      $display("FAIL min_on_hold: ticks %0d bad %0d want %0d/0", ticks, bad, MON);
    end
    checks++;
    if (bus.state_o !== 3'd3 || bus.compressor_o !== 1'b1) begin
      errors++;
      $display("FAIL min_on_run: state %0d comp %b want 3/1", bus.state_o, bus.compressor_o);
    end
    cycle();
    checks++;
    if (bus.state_o !== 3'd0 || bus.compressor_o !== 1'b0 || bus.fan_o !== 1'b0) begin
      errors++;
      $display("FAIL min_on_off: state %0d comp %b want 0/0", bus.state_o, bus.compressor_o);
    end
  endtask

  task automatic test_hysteresis();
    bit ok;
    int bad = 0;
    bus.enable_i = 1'b1;
    bus.setpoint_i = 6'd20;
    set_temp(22, 22);
    wait_model(3, 80, ok);
    checks++;
    if (!ok || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL hyst_reach_run: ok %b got %b want %b", ok, dut_vec(), exp_vec());
    end
    set_temp(19, 19);
    repeat (6) begin
      cycle();
      if (bus.state_o !== 3'd3 || bus.compressor_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hyst_temp19_on: %0d bad cycles want 0", bad);
    end
    set_temp(18, 19);
    cycle();
    checks++;
    if (bus.state_o !== 3'd0 || bus.compressor_o !== 1'b0) begin
      errors++;
      $display("FAIL hyst_temp18_off: state %0d comp %b want 0/0", bus.state_o, bus.compressor_o);
    end
    set_temp(20, 22);
    wait_model(1, 80, ok);
    bad = 0;
    repeat (6) begin
      cycle();
      if (bus.state_o !== 3'd1 || bus.compressor_o !== 1'b0) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL hyst_temp21_idle: ok %b bad %0d want 1/0", ok, bad);
    end
    set_temp(22, 22);
    cycle();
    checks++;
    if (bus.state_o !== 3'd2 || bus.compressor_o !== 1'b1) begin
      errors++;
      $display("FAIL hyst_temp22_cool: state %0d comp %b want 2/1", bus.state_o, bus.compressor_o);
    end
  endtask

  task automatic test_fault();
    int ticks = 0;
    int n = 0;
    set_temp(40, 30);
    cycle();
    checks++;
    if ({bus.state_o, bus.compressor_o, bus.fan_o, bus.fault_o} !== {3'd4, 3'b001}) begin
      errors++;
      $display("FAIL fault_enter: state %0d comp %b fault %b want 4/0/1",
               bus.state_o, bus.compressor_o, bus.fault_o);
    end
    set_temp(40, 35);
    cycle();
    checks++;
    if (bus.state_o !== 3'd0 || bus.fault_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit: state %0d fault %b want 0/0", bus.state_o, bus.fault_o);
    end
    while (bus.state_o === 3'd0 && n < 60) begin
      if (bus.sec_tick_o === 1'b1) ticks++;
      cycle();
      n++;
    end
    checks++;
    if (ticks != MOFF || bus.state_o !== 3'd1) begin
      errors++;
      $display("FAIL fault_lockout: ticks %0d state %0d want %0d/1", ticks, bus.state_o, MOFF);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    int bad = 0;
    bus.enable_i = 1'b1;
    bus.setpoint_i = 6'd63;
    set_temp(63, 63);
    repeat (12) begin
      cycle();
      if (bus.state_o !== 3'd1 || bus.compressor_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL boundary_hi_nowrap: %0d bad cycles want 0", bad);
    end
    bus.setpoint_i = 6'd1;
    set_temp(10, 10);
    wait_model(3, 80, ok);
    set_temp(1, 1);
    bad = 0;
    repeat (5) begin
      cycle();
      if (bus.state_o !== 3'd3) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL boundary_temp1_on: ok %b bad %0d want 1/0", ok, bad);
    end
    set_temp(0, 0);
    cycle();
    checks++;
    if (bus.state_o !== 3'd0 || bus.compressor_o !== 1'b0) begin
      errors++;
      $display("FAIL boundary_lo_sat: state %0d comp %b want 0/0", bus.state_o, bus.compressor_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int ticks = 0;
    int first = -1;
    int n = 0;
    bus.enable_i = 1'b1;
    bus.setpoint_i = 6'd20;
    set_temp(30, 30);
    wait_model(3, 100, ok);
    checks++;
    if (!ok || bus.compressor_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: ok %b comp %b want 1/1", ok, bus.compressor_o);
    end
    rst_n = 1'b0;
    cycle();
    checks++;
    if (dut_vec() !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want %b", dut_vec(), 7'd0);
    end
    rst_n = 1'b1;
    while (bus.state_o === 3'd0 && n < 60) begin
      cycle();
      n++;
      if (bus.state_o === 3'd0 && bus.sec_tick_o === 1'b1) begin
        ticks++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (first != TD - 1 || ticks != MOFF || n != MOFF * TD || bus.state_o !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid_lockout: first %0d ticks %0d cycles %0d state %0d want %0d/%0d/%0d/1",
               first, ticks, n, bus.state_o, TD - 1, MOFF, MOFF * TD);
    end
  endtask

  function automatic int clamp63(input int v);
    return (v < 0) ? 0 : ((v > 63) ? 63 : v);
  endfunction

  task automatic test_random();
    int s1, s2;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) begin
        s1 = $urandom_range(0, 63);
        if ($urandom_range(0, 9) == 0) s2 = $urandom_range(0, 63);
        else s2 = clamp63(s1 + $urandom_range(0, 20) - 10);
        set_temp(s1, s2);
        bus.setpoint_i = 6'(clamp63(s1 + $urandom_range(0, 12) - 6));
        bus.enable_i = ($urandom_range(0, 9) != 0);
      end
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    bus.setpoint_i = '0;
    set_temp(0, 0);
    test_reset();
    test_power_up();
    test_min_on();
    test_hysteresis();
    test_fault();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac_compressor_ctrl.md
Name: ac_compressor_ctrl

Overview:
Sequencing controller for the air-conditioner compressor and fan. It averages the two 6-bit temperature sensors and compares the result against a setpoint with hysteresis. It enforces minimum compressor on and off times, default 10 and 15 minutes, using a 1 s tick derived from the 100 kHz PLL clock. It sits between the sensor inputs and the compressor/fan drive, clocked by the PLL output.

Parameters:
WIDTH, 5, sensor/setpoint MSB index; buses are WIDTH+1 bits.
TICK_DIV, 100000, clk_i cycles per one-second tick.
MIN_ON_S, 600, minimum compressor on time, seconds.
MIN_OFF_S, 900, minimum compressor off time, seconds; also applies after reset.
HYST, 2, hysteresis band, sensor LSBs.
FAULT_DELTA, 8, maximum allowed |s1_i - s2_i| before fault.

Ports:
clk_i  in  1  100 kHz PLL clock
rst_n_i  in  1  synchronous active-low reset
s1_i  in  WIDTH+1  sensor 1 temperature, unsigned
s2_i  in  WIDTH+1  sensor 2 temperature, unsigned
setpoint_i  in  WIDTH+1  target temperature, unsigned
enable_i  in  1  user cooling request
compressor_o  out  1  compressor drive
fan_o  out  1  fan drive
state_o  out  3  current FSM state encoding
sec_tick_o  out  1  one-cycle pulse per second
fault_o  out  1  sensor disagreement flag

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - state <= OFF_LOCK; sec_cnt <= MIN_OFF_S; prescaler <= 0.
  - All outputs 0; state_o=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - sec_tick_o=1 for exactly the cycle where count==TICK_DIV-1.
- Temperature and fault detection (combinational, registered into the FSM decision):
  - temp = (s1_i + s2_i) >> 1, summed in WIDTH+2 bits with no overflow.
  - diff = |s1_i - s2_i|.
  - hi_thr = setpoint_i + HYST, in WIDTH+2 bits (no wrap).
  - lo_thr = setpoint_i - HYST, saturated at 0.
- Lock timer:
  - Loaded with N on entry to a lock state; decrements on each sec tick.
  - The state exits on the tick that reaches 0, i.e. exactly N ticks after entry.
- FSM states and encoding (state_o):
  - OFF_LOCK=0: compressor 0, fan 0. Counts MIN_OFF_S ticks, then -> OFF_READY.
  - OFF_READY=1: compressor 0, fan 0. If enable_i && temp >= hi_thr -> COOL_LOCK, load MIN_ON_S.
  - COOL_LOCK=2: compressor 1, fan 1. Counts MIN_ON_S ticks, then -> COOL_RUN. enable_i and temperature are ignored here (minimum on time is guaranteed).
  - COOL_RUN=3: compressor 1, fan 1. If !enable_i || temp <= lo_thr -> OFF_LOCK, load MIN_OFF_S.
  - FAULT=4: compressor 0, fan 0, fault_o=1. When diff <= FAULT_DELTA -> OFF_LOCK, load MIN_OFF_S.
- Fault priority: diff > FAULT_DELTA in any state forces FAULT on the next edge. This overrides the minimum on time and any lock.
- Outputs are registered and decoded from the next state. compressor_o therefore changes on the same edge as the state transition, with 1-cycle latency from the input condition.
- A tick coinciding with a leave condition: the leave condition wins; the timer is reloaded for the new state.
- Reset mid-operation: compressor_o drops on that edge and the full MIN_OFF_S lockout restarts.
- States 5-7 are unreachable; if entered, go to FAULT.

Decomposition:
- Shared package ac_pkg holds:
  - the state enum/localparams (OFF_LOCK..FAULT, 3-bit);
  - TICK_DIV_DEFAULT = 100000;
  - the default MIN_ON_S/MIN_OFF_S values.
- One sub-module, ac_sec_tick: prescaler with clk_i, rst_n_i and TICK_DIV parameter; output tick_o.
- The FSM, timer and compare logic stay in ac_compressor_ctrl.

Test Plan:
Simulation parameters: TICK_DIV=4, MIN_ON_S=3, MIN_OFF_S=5, HYST=2, FAULT_DELTA=8.
1. Power-up lockout: rst_n_i low 2 cycles, enable_i=1, s1=s2=30, setpoint=20 -> state 0 for 5 ticks (20 cycles), compressor_o=0 throughout, then state 1 and next cycle state 2 with compressor_o=1.
2. Minimum on time: in COOL_LOCK drop enable_i and set s1=s2=10 -> compressor_o held 1 for exactly 3 ticks, then COOL_RUN for one cycle, then OFF_LOCK with compressor_o=0.
3. Hysteresis: setpoint=20, COOL_RUN; temp 19 -> stays on; temp 18 -> off. In OFF_READY: temp 21 -> stays off; temp 22 -> COOL_LOCK.
4. Sensor fault: in COOL_LOCK set s1=40, s2=30 -> next edge state 4, compressor_o=0, fault_o=1. Set s2=35 -> OFF_LOCK, fault_o=0, 5-tick lockout.
5. Boundary: setpoint=63, temp 63 -> never cools, because hi_thr=65 is not wrapped. setpoint=1, temp 0 in COOL_RUN -> lo_thr saturates to 0 and the compressor turns off.
6. Reset mid-cooling: assert rst_n_i during COOL_RUN -> all outputs 0 on that edge, prescaler restarts, full 5-tick lockout observed.
